// File: rtl/fadd_issue.sv
// Issue/retire wrapper for the pipelined single-precision fadd: credit-based issue, tag tracking, result FIFO.
// Optional build macro FADD_ISSUE_PERF_EN adds issued/stall performance counters.
module fadd_issue #(
  parameter int FADD_LAT  = 1,
  parameter int OUT_DEPTH = 2,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fadd_x1,
  output logic [31:0]      fadd_x2,
  input  logic [31:0]      fadd_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
);

  // Stage 0 mirrors fadd's operand sampling register; the last stage lines up with fadd_y.
  localparam int PIPE_N = FADD_LAT + 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

  function automatic logic [31:0] flip_sign(input logic [31:0] x, input logic neg);
    return {x[31] ^ neg, x[30:0]};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0] used_q;
  logic             fire;
  logic             pop;

  assign fadd_x1   = req_rs1;
  assign fadd_x2   = flip_sign(req_rs2, req_sub);
  assign req_ready = (used_q < DEPTH_C);
  assign fire      = req_valid && req_ready;
  assign pop       = res_valid && res_ready;

  // ---- issue: credit counter covers in-flight ops plus FIFO occupancy ----
  always_ff @(posedge clk) begin
    if (rst) begin
      used_q <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   used_q <= used_q + CNT_W'(1);
        2'b01:   used_q <= used_q - CNT_W'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  logic             vld_p [PIPE_N];
  logic [TAG_W-1:0] tag_p [PIPE_N];

  // ---- tag pipe: tracks fadd stages p0 .. p(FADD_LAT) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_N; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= fire;
      for (int i = 1; i < PIPE_N; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= req_tag;
    for (int i = 1; i < PIPE_N; i++) tag_p[i] <= tag_p[i-1];
  end

  logic             cap_vld;
  logic [TAG_W-1:0] cap_tag;

  assign cap_vld = vld_p[PIPE_N-1];
  assign cap_tag = tag_p[PIPE_N-1];

  logic [31:0]      mem_data [OUT_DEPTH];
  logic [TAG_W-1:0] mem_tag  [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // ---- capture/retire: result FIFO, pointers wrap modulo OUT_DEPTH ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (cap_vld) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      case ({cap_vld, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cap_vld) begin
      mem_data[wr_ptr] <= fadd_y;
      mem_tag[wr_ptr]  <= cap_tag;
    end
  end

  // Head is masked when empty so stale storage never leaks after reset.
  assign res_valid = (count_q != '0);
  assign res_data  = res_valid ? mem_data[rd_ptr] : '0;
  assign res_tag   = res_valid ? mem_tag[rd_ptr]  : '0;

`ifdef FADD_ISSUE_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (fire)                    issued_q <= issued_q + 32'd1;
      if (req_valid && !req_ready) stall_q  <= stall_q + 32'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_fadd_issue.sv
// Self-checking bench for fadd_issue: fadd stand-in, directed vectors, corner sequences and a random run
// scored against a transaction-level queue model.
module tb_fadd_issue;
  localparam int FADD_LAT  = 1;
  localparam int OUT_DEPTH = 2;
  localparam int TAG_W     = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_sub;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      fadd_x1;
  logic [31:0]      fadd_x2;
  logic [31:0]      fadd_y;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;

  always #5 clk = ~clk;

  fadd_issue #(.FADD_LAT(FADD_LAT), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  // fadd stand-in: exact for the directed IEEE vectors, otherwise a deterministic operand mix.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h00000000;
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
  endfunction

  // Operands sampled at edge E, y presented after edge E+FADD_LAT.
  logic [31:0] fstage [FADD_LAT+1];
  always @(posedge clk) begin
    fstage[0] <= fmodel(fadd_x1, fadd_x2);
    for (int i = 1; i <= FADD_LAT; i++) fstage[i] <= fstage[i-1];
  end
  assign fadd_y = fstage[FADD_LAT];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } op_t;

  op_t         q[$];
  int          cyc = 0;
  logic [31:0] m_issued = 0;
  logic [31:0] m_stall  = 0;
  bit          after_rst = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic        exp_valid, exp_ready, m_fire, m_pop;
    logic [31:0] exp_x2;
    op_t         nop;
    if (rst) begin
      q.delete();
      m_issued  = 0;
      m_stall   = 0;
      after_rst = 1'b1;
    end else begin
      exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      exp_ready = (q.size() < OUT_DEPTH);
      exp_x2    = req_sub ? (req_rs2 ^ 32'h8000_0000) : req_rs2;
      check32("mon_res_valid", 32'(res_valid), 32'(exp_valid));
      check32("mon_req_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_valid) begin
        check32("mon_res_data", res_data, q[0].data);
        check32("mon_res_tag", 32'(res_tag), 32'(q[0].tag));
        after_rst = 1'b0;
      end else if (after_rst) begin
        check32("mon_rst_data", res_data, 32'h0);
        check32("mon_rst_tag", 32'(res_tag), 32'h0);
      end
      check32("mon_fadd_x1", fadd_x1, req_rs1);
      check32("mon_fadd_x2", fadd_x2, exp_x2);
`ifdef FADD_ISSUE_PERF_EN
      check32("mon_perf_issued", perf_issued, m_issued);
      check32("mon_perf_stall", perf_stall, m_stall);
`else
      check32("mon_perf_issued", perf_issued, 32'h0);
      check32("mon_perf_stall", perf_stall, 32'h0);
`endif
      m_pop  = exp_valid && res_ready;
      m_fire = req_valid && exp_ready;
      if (req_valid && !exp_ready) m_stall = m_stall + 1;
      if (m_pop) void'(q.pop_front());
      if (m_fire) begin
        nop.data = fmodel(req_rs1, exp_x2);
        nop.tag  = req_tag;
        nop.rdy  = cyc + 1 + FADD_LAT + 1;
        q.push_back(nop);
        m_issued = m_issued + 1;
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic             sub;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_x2;
    logic [31:0]      exp_y;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int          fires;
    logic        f;
    logic [31:0] got[$];
    int          guard;

    vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 5'd3,  32'h40000000, 32'h40400000};
    vecs[1] = '{1'b1, 32'h40400000, 32'h3F800000, 5'd7,  32'hBF800000, 32'h40000000};
    vecs[2] = '{1'b0, 32'h40000000, 32'h40000000, 5'd31, 32'h40000000, 32'h40800000};
    vecs[3] = '{1'b1, 32'h3F800000, 32'h3F800000, 5'd0,  32'hBF800000, 32'h00000000};

    rst = 1'b1; req_valid = 1'b0; req_sub = 1'b0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    res_ready = 1'b0;
    tick(); tick();
    check32("rst_req_ready", 32'(req_ready), 32'h1);
    check32("rst_res_valid", 32'(res_valid), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_sub = vecs[i].sub; req_rs1 = vecs[i].rs1;
      req_rs2 = vecs[i].rs2; req_tag = vecs[i].tag;
      #1;
      check32("vec_fadd_x2", fadd_x2, vecs[i].exp_x2);
      tick();
      req_valid = 1'b0;
      check32("vec_lat_e0", 32'(res_valid), 32'h0);
      tick();
      check32("vec_lat_e1", 32'(res_valid), 32'h0);
      tick();
      check32("vec_lat_e2", 32'(res_valid), 32'h1);
      check32("vec_data", res_data, vecs[i].exp_y);
      check32("vec_tag", 32'(res_tag), 32'(vecs[i].tag));
      tick();
      check32("vec_hold_valid", 32'(res_valid), 32'h1);
      check32("vec_hold_data", res_data, vecs[i].exp_y);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check32("vec_popped", 32'(res_valid), 32'h0);
    end

    // Fill with results blocked: two fires then five stalled cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 1'b1; req_tag = 5'd10; req_rs1 = $urandom; req_rs2 = $urandom; req_sub = 1'b0;
    fires = 0;
    for (int k = 0; k < 7; k++) begin
      f = req_ready;
      tick();
      if (f) begin
        fires++;
        req_tag = req_tag + 1'b1; req_rs1 = $urandom; req_rs2 = $urandom; req_sub = ~req_sub;
      end
    end
    check32("s3_fires", 32'(fires), 32'd2);
    check32("s3_req_ready_full", 32'(req_ready), 32'h0);
`ifdef FADD_ISSUE_PERF_EN
    check32("s3_perf_issued", perf_issued, 32'd2);
    check32("s3_perf_stall", perf_stall, 32'd5);
`else
    check32("s3_perf_issued", perf_issued, 32'd0);
    check32("s3_perf_stall", perf_stall, 32'd0);
`endif
    check32("s3_head_tag", 32'(res_tag), 32'd10);
    res_ready = 1'b1;
    tick();
    check32("s3_credit_back", 32'(req_ready), 32'h1);
    check32("s3_second_tag", 32'(res_tag), 32'd11);
    for (int k = 0; k < 12; k++) begin
      f = req_ready;
      tick();
      if (f) begin req_tag = req_tag + 1'b1; req_rs1 = $urandom; req_rs2 = $urandom; end
    end
    req_valid = 1'b0;
    repeat (8) tick();

    // Stream tags 0..7 with results always accepted.
    req_valid = 1'b1; req_tag = '0; req_sub = 1'b0; res_ready = 1'b1;
    guard = 0;
    while (got.size() < 8 && guard < 200) begin
      if (res_valid) got.push_back(32'(res_tag));
      f = req_valid && req_ready;
      tick();
      if (f) begin
        if (req_tag == 5'd7) req_valid = 1'b0;
        else begin req_tag = req_tag + 1'b1; req_rs1 = $urandom; req_rs2 = $urandom; end
      end
      guard++;
    end
    check32("s4_count", 32'(got.size()), 32'd8);
    for (int k = 0; k < got.size(); k++) check32("s4_order", got[k], 32'(k));
    req_valid = 1'b0;
    repeat (4) tick();

    // Reset lands on the first capture edge: both in-flight ops must vanish.
    res_ready = 1'b0;
    req_valid = 1'b1; req_tag = 5'd20; req_rs1 = $urandom; req_rs2 = $urandom;
    tick();
    req_tag = 5'd21; req_rs1 = $urandom;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check32("s5_no_result", 32'(res_valid), 32'h0);
      check32("s5_req_ready", 32'(req_ready), 32'h1);
      tick();
    end

    // Random traffic with occasional reset, scored by the model.
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(99) == 0);
      req_valid = $urandom_range(1);
      req_sub   = $urandom_range(1);
      req_rs1   = $urandom;
      req_rs2   = $urandom;
      req_tag   = TAG_W'($urandom);
      res_ready = ($urandom_range(3) != 0);
      tick();
    end
    rst = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
